reg_dump_reader: RTL



---
 rtl/reg_dump_reader.sv | 97 +++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks a register-file read port in ascending order and streams
// index/data beats over valid/ready with a running XOR checksum. Optional macro REG_DUMP_SKIP_X0_EN skips x0.
module reg_dump_reader #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [4:0]        raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] csum
);

  // Handshake: a beat transfers on a rising edge where out_valid and out_ready are both 1;
  // while out_valid is 1 the beat (out_idx/out_data/out_last) holds stable until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

`ifdef REG_DUMP_SKIP_X0_EN
  localparam logic [4:0] FIRST = 5'd1;
`else
  localparam logic [4:0] FIRST = 5'd0;
`endif
  localparam logic [4:0] LAST = 5'(NREGS - 1);

  state_t     state;
  logic [4:0] cnt;

  // The read address is the counter register itself, so it is always a defined value.
  assign raddr = cnt;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      out_valid <= 1'b0;
      out_idx   <= 5'd0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      csum      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= FIRST;
            csum  <= '0;
            state <= READ;
          end
        end
        READ: begin
          // Capture happens on the same edge as any concurrent write, so the old value is taken.
          out_data  <= rdata;
          out_idx   <= cnt;
          out_last  <= (cnt == LAST);
          csum      <= csum ^ rdata;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt   <= cnt + 5'd1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
